// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit processor: fetch/decode/execute/memory/write-back sequencing.
// Define MEM_WAIT_EN to make FETCH, MEM_RD and MEM_WR wait for I_MemReady.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] I_Opcode,
  input  logic       I_MemReady,
  input  logic       I_Zero,
  output logic       C_ALUSrc_A,
  output logic [2:0] C_ALUSrc_B,
  output logic [1:0] C_RegDstRead1R,
  output logic       C_RegDstRead2R,
  output logic       C_SignExtend,
  output logic [1:0] C_ALUOp,
  output logic       C_PCWrite,
  output logic       C_IRWrite,
  output logic       C_MemRead,
  output logic       C_MemWrite,
  output logic       C_RegWrite,
  output logic       C_MemToReg,
  output logic       C_Illegal,
  output logic       C_Halted,
  output logic [3:0] C_State
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC_R = 4'd3,
    EXEC_I = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WR = 4'd7,
    WB_ALU = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_e;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       memDone;

`ifdef MEM_WAIT_EN
  assign memDone = I_MemReady;
`else
  // Zero-wait memory: the ready input is deliberately ignored.
  assign memDone = I_MemReady | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (memDone) state_d = DECODE;
      DECODE: begin
        op_d = I_Opcode;
        case (I_Opcode)
          OP_R:           state_d = EXEC_R;
          OP_ADDI, OP_ORI: state_d = EXEC_I;
          OP_LW, OP_SW:   state_d = ADDR;
          OP_BEQ:         state_d = BRANCH;
          OP_JMP:         state_d = JUMP;
          OP_HLT:         state_d = HALT;
          default:        state_d = FETCH;
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR:   state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: if (memDone) state_d = WB_MEM;
      MEM_WR: if (memDone) state_d = FETCH;
      WB_ALU, WB_MEM, BRANCH, JUMP: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    C_ALUSrc_A     = 1'b0;
    C_ALUSrc_B     = 3'b000;
    C_RegDstRead1R = 2'b00;
    C_RegDstRead2R = 1'b0;
    C_SignExtend   = 1'b0;
    C_ALUOp        = ALU_ADD;
    C_PCWrite      = 1'b0;
    C_IRWrite      = 1'b0;
    C_MemRead      = 1'b0;
    C_MemWrite     = 1'b0;
    C_RegWrite     = 1'b0;
    C_MemToReg     = 1'b0;
    C_Illegal      = 1'b0;
    C_Halted       = 1'b0;
    C_State        = state_q;
    case (state_q)
      FETCH: begin
        C_ALUSrc_B = 3'b001;
        C_MemRead  = 1'b1;
        C_IRWrite  = memDone;
        C_PCWrite  = memDone;
      end
      DECODE: begin
        C_ALUSrc_B   = 3'b011;
        C_SignExtend = 1'b1;
        C_Illegal    = !(I_Opcode inside {OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW,
                                         OP_BEQ, OP_JMP, OP_HLT});
      end
      EXEC_R: begin
        C_ALUSrc_A = 1'b1;
        C_ALUOp    = ALU_FUNC;
      end
      EXEC_I: begin
        C_ALUSrc_A   = 1'b1;
        C_ALUSrc_B   = 3'b010;
        C_SignExtend = (op_q == OP_ADDI);
        C_ALUOp      = (op_q == OP_ADDI) ? ALU_ADD : ALU_OR;
      end
      ADDR: begin
        C_ALUSrc_A     = 1'b1;
        C_RegDstRead1R = 2'b10;
        C_ALUSrc_B     = 3'b010;
        C_SignExtend   = 1'b1;
      end
      MEM_RD: C_MemRead = 1'b1;
      MEM_WR: begin
        C_MemWrite     = 1'b1;
        C_RegDstRead2R = 1'b1;
      end
      WB_ALU: C_RegWrite = 1'b1;
      WB_MEM: begin
        C_RegWrite = 1'b1;
        C_MemToReg = 1'b1;
      end
      BRANCH: begin
        C_ALUSrc_A     = 1'b1;
        C_RegDstRead1R = 2'b01;
        C_ALUOp        = ALU_SUB;
        C_PCWrite      = I_Zero;
      end
      JUMP: begin
        C_ALUSrc_B = 3'b100;
        C_PCWrite  = 1'b1;
      end
      HALT: C_Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-path reference model plus directed literal checks.
// Honours MEM_WAIT_EN the same way as the design.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] I_Opcode = 4'd0;
  logic       I_MemReady = 1'b1;
  logic       I_Zero = 1'b0;
  logic       C_ALUSrc_A;
  logic [2:0] C_ALUSrc_B;
  logic [1:0] C_RegDstRead1R;
  logic       C_RegDstRead2R;
  logic       C_SignExtend;
  logic [1:0] C_ALUOp;
  logic       C_PCWrite, C_IRWrite, C_MemRead, C_MemWrite;
  logic       C_RegWrite, C_MemToReg, C_Illegal, C_Halted;
  logic [3:0] C_State;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  // Reference model: current state plus the remaining state path of the instruction.
  int         mState = 0;
  logic [3:0] mOp = 4'd0;
  int         path[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .I_Opcode(I_Opcode), .I_MemReady(I_MemReady),
    .I_Zero(I_Zero), .C_ALUSrc_A(C_ALUSrc_A), .C_ALUSrc_B(C_ALUSrc_B),
    .C_RegDstRead1R(C_RegDstRead1R), .C_RegDstRead2R(C_RegDstRead2R),
    .C_SignExtend(C_SignExtend), .C_ALUOp(C_ALUOp), .C_PCWrite(C_PCWrite),
    .C_IRWrite(C_IRWrite), .C_MemRead(C_MemRead), .C_MemWrite(C_MemWrite),
    .C_RegWrite(C_RegWrite), .C_MemToReg(C_MemToReg), .C_Illegal(C_Illegal),
    .C_Halted(C_Halted), .C_State(C_State)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isLegal(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd15);
  endfunction

  function automatic bit memDone();
    return WAIT_EN ? I_MemReady : 1'b1;
  endfunction

  // Output vector order: A, B[2:0], Read1R[1:0], Read2R, SignExt, ALUOp[1:0],
  // PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg, Illegal, Halted.
  function automatic logic [17:0] expOut(input int st, input logic [3:0] opL,
                                         input logic [3:0] opIn, input logic z, input logic done);
    logic a, r2, se, pcw, irw, mr, mw, rw, m2r, ill, hlt;
    logic [2:0] b;
    logic [1:0] r1, alu;
    {a, r2, se, pcw, irw, mr, mw, rw, m2r, ill, hlt} = '0;
    b = 3'd0; r1 = 2'd0; alu = 2'd0;
    case (st)
      1:  begin b = 3'd1; mr = 1; irw = done; pcw = done; end
      2:  begin b = 3'd3; se = 1; ill = !isLegal(opIn); end
      3:  begin a = 1; alu = 2'd2; end
      4:  begin a = 1; b = 3'd2; se = (opL == 4'd1); alu = (opL == 4'd1) ? 2'd0 : 2'd3; end
      5:  begin a = 1; r1 = 2'd2; b = 3'd2; se = 1; end
      6:  mr = 1;
      7:  begin mw = 1; r2 = 1; end
      8:  rw = 1;
      9:  begin rw = 1; m2r = 1; end
      10: begin a = 1; r1 = 2'd1; alu = 2'd1; pcw = z; end
      11: begin b = 3'd4; pcw = 1; end
      12: hlt = 1;
      default: ;
    endcase
    return {a, b, r1, r2, se, alu, pcw, irw, mr, mw, rw, m2r, ill, hlt};
  endfunction

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic modelStep();
    if (!rst_n) begin
      mState = 0;
      path.delete();
    end else begin
      case (mState)
        0: mState = 1;
        1: if (memDone()) mState = 2;
        2: begin
          mOp = I_Opcode;
          case (I_Opcode)
            4'd0:       path = '{3, 8, 1};
            4'd1, 4'd2: path = '{4, 8, 1};
            4'd3:       path = '{5, 6, 9, 1};
            4'd4:       path = '{5, 7, 1};
            4'd5:       path = '{10, 1};
            4'd6:       path = '{11, 1};
            4'd15:      path = '{12};
            default:    path = '{1};
          endcase
          mState = path.pop_front();
        end
        6, 7: if (memDone()) mState = path.pop_front();
        12: mState = 12;
        default: mState = path.pop_front();
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cycle-state", {28'd0, C_State}, mState);
      checkOutput("cycle-outputs",
        {14'd0, C_ALUSrc_A, C_ALUSrc_B, C_RegDstRead1R, C_RegDstRead2R, C_SignExtend,
         C_ALUOp, C_PCWrite, C_IRWrite, C_MemRead, C_MemWrite, C_RegWrite, C_MemToReg,
         C_Illegal, C_Halted},
        {14'd0, expOut(mState, mOp, I_Opcode, I_Zero, memDone())});
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic z, input logic rdy);
    I_Opcode = op;
    I_Zero = z;
    I_MemReady = rdy;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic stepExpect(input logic [3:0] op, input logic z, input logic rdy, input int st);
    applyStimulus(op, z, rdy);
    checkOutput("literal-state", {28'd0, C_State}, st);
    advance();
  endtask

  function automatic logic [3:0] randOp();
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 6));
    if (r == 4'd15) r = 4'd0;
    return r;
  endfunction

  initial begin
    int guard;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    checkEn = 1'b1;
    repeat (3) begin applyStimulus(4'd0, 1'b0, 1'b1); advance(); end
    checkOutput("reset-state", {28'd0, C_State}, 0);
    checkOutput("reset-memread", {31'd0, C_MemRead}, 0);
    rst_n = 1'b1;

    // Reset release with an R-type instruction held on the opcode.
    stepExpect(4'd0, 1'b0, 1'b1, 0);
    stepExpect(4'd0, 1'b0, 1'b1, 1);
    stepExpect(4'd0, 1'b0, 1'b1, 2);
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("r-exec-state", {28'd0, C_State}, 3);
    checkOutput("r-exec-aluop", {30'd0, C_ALUOp}, 2);
    advance();
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("r-wb-state", {28'd0, C_State}, 8);
    checkOutput("r-wb-regwrite", {31'd0, C_RegWrite}, 1);
    advance();

    // LW
    stepExpect(4'd3, 1'b0, 1'b1, 1);
    stepExpect(4'd3, 1'b0, 1'b1, 2);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("lw-addr-state", {28'd0, C_State}, 5);
    checkOutput("lw-addr-read1r", {30'd0, C_RegDstRead1R}, 2);
    checkOutput("lw-addr-srcb", {29'd0, C_ALUSrc_B}, 2);
    checkOutput("lw-addr-sext", {31'd0, C_SignExtend}, 1);
    advance();
    stepExpect(4'd3, 1'b0, 1'b1, 6);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("lw-wbmem-state", {28'd0, C_State}, 9);
    checkOutput("lw-wbmem-memtoreg", {31'd0, C_MemToReg}, 1);
    advance();

    // BEQ taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      stepExpect(4'd5, 1'(t), 1'b1, 1);
      stepExpect(4'd5, 1'(t), 1'b1, 2);
      applyStimulus(4'd5, 1'(t), 1'b1);
      checkOutput("beq-state", {28'd0, C_State}, 10);
      checkOutput("beq-pcwrite", {31'd0, C_PCWrite}, t);
      checkOutput("beq-read1r", {30'd0, C_RegDstRead1R}, 1);
      checkOutput("beq-aluop", {30'd0, C_ALUOp}, 1);
      advance();
    end

    // ORI then ADDI
    for (int k = 2; k >= 1; k--) begin
      stepExpect(4'(k), 1'b0, 1'b1, 1);
      stepExpect(4'(k), 1'b0, 1'b1, 2);
      applyStimulus(4'(k), 1'b0, 1'b1);
      checkOutput("execi-state", {28'd0, C_State}, 4);
      checkOutput("execi-sext", {31'd0, C_SignExtend}, (k == 1) ? 1 : 0);
      checkOutput("execi-aluop", {30'd0, C_ALUOp}, (k == 1) ? 0 : 3);
      advance();
      stepExpect(4'(k), 1'b0, 1'b1, 8);
    end

    // Illegal opcode 1010
    stepExpect(4'd10, 1'b0, 1'b1, 1);
    applyStimulus(4'd10, 1'b0, 1'b1);
    checkOutput("illegal-pulse", {31'd0, C_Illegal}, 1);
    advance();
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("illegal-next-state", {28'd0, C_State}, 1);
    checkOutput("illegal-pulse-end", {31'd0, C_Illegal}, 0);
    advance();
    // Finish the R instruction that was just fetched.
    stepExpect(4'd0, 1'b0, 1'b1, 2);
    stepExpect(4'd0, 1'b0, 1'b1, 3);
    stepExpect(4'd0, 1'b0, 1'b1, 8);

    // Randomized instruction stream, halt excluded.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randOp(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      advance();
    end
    guard = 0;
    while (mState != 1 && guard < 50) begin
      applyStimulus(4'd0, 1'b0, 1'b1);
      advance();
      guard++;
    end
    checkOutput("sync-to-fetch", mState, 1);

    // Reset asserted while SW is in MEM_WR.
    stepExpect(4'd4, 1'b0, 1'b1, 1);
    stepExpect(4'd4, 1'b0, 1'b1, 2);
    stepExpect(4'd4, 1'b0, 1'b1, 5);
    applyStimulus(4'd4, 1'b0, 1'b0);
    checkOutput("sw-memwr-state", {28'd0, C_State}, 7);
    checkOutput("sw-memwrite", {31'd0, C_MemWrite}, 1);
    #2 rst_n = 1'b0;
    #1;
    mState = 0;
    checkOutput("midreset-state", {28'd0, C_State}, 0);
    checkOutput("midreset-memwrite", {31'd0, C_MemWrite}, 0);
    advance();
    rst_n = 1'b1;
    stepExpect(4'd0, 1'b0, 1'b1, 0);

`ifdef MEM_WAIT_EN
    // Fetch stalled for three cycles.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(4'd0, 1'b0, (s == 3));
      checkOutput("stall-state", {28'd0, C_State}, 1);
      checkOutput("stall-irwrite", {31'd0, C_IRWrite}, (s == 3) ? 1 : 0);
      advance();
    end
    stepExpect(4'd0, 1'b0, 1'b1, 2);
    stepExpect(4'd0, 1'b0, 1'b1, 3);
    stepExpect(4'd0, 1'b0, 1'b1, 8);
`endif

    // Halt and stay halted.
    stepExpect(4'd15, 1'b0, 1'b1, 1);
    stepExpect(4'd15, 1'b0, 1'b1, 2);
    for (int h = 0; h < 10; h++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      advance();
    end
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("halt-state", {28'd0, C_State}, 12);
    checkOutput("halted", {31'd0, C_Halted}, 1);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
